// File: rtl/lfsr_rand_multi.sv
// XNOR Fibonacci LFSR random source: serves N_CH fields of OUT_W bits per request over valid/ready.
// Optional macro LFSR_FREERUN_EN: the LFSR also steps in IDLE (without seed_load) and in HOLD.
module lfsr_rand_multi #(
    parameter int          WIDTH = 10,
    parameter int          OUT_W = 2,
    parameter int          N_CH  = 4,
    parameter logic [31:0] SEED  = 32'h029
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  seed_load,
    input  logic [WIDTH-1:0]      seed_in,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic [N_CH*OUT_W-1:0] rnd_data,
    output logic                  seed_err
);

    // Maximal-length XNOR tap sets (1-based bit positions, XAPP052 table).
    function automatic logic [31:0] tap_mask(input int w);
        logic [31:0] m;
        m = '0;
        case (w)
            3:  m = (32'd1 << 2)  | (32'd1 << 1);
            4:  m = (32'd1 << 3)  | (32'd1 << 2);
            5:  m = (32'd1 << 4)  | (32'd1 << 2);
            6:  m = (32'd1 << 5)  | (32'd1 << 4);
            7:  m = (32'd1 << 6)  | (32'd1 << 5);
            8:  m = (32'd1 << 7)  | (32'd1 << 5)  | (32'd1 << 4)  | (32'd1 << 3);
            9:  m = (32'd1 << 8)  | (32'd1 << 4);
            10: m = (32'd1 << 9)  | (32'd1 << 6);
            11: m = (32'd1 << 10) | (32'd1 << 8);
            12: m = (32'd1 << 11) | (32'd1 << 5)  | (32'd1 << 3)  | (32'd1 << 0);
            13: m = (32'd1 << 12) | (32'd1 << 3)  | (32'd1 << 2)  | (32'd1 << 0);
            14: m = (32'd1 << 13) | (32'd1 << 4)  | (32'd1 << 2)  | (32'd1 << 0);
            15: m = (32'd1 << 14) | (32'd1 << 13);
            16: m = (32'd1 << 15) | (32'd1 << 14) | (32'd1 << 12) | (32'd1 << 3);
            17: m = (32'd1 << 16) | (32'd1 << 13);
            18: m = (32'd1 << 17) | (32'd1 << 10);
            19: m = (32'd1 << 18) | (32'd1 << 5)  | (32'd1 << 1)  | (32'd1 << 0);
            20: m = (32'd1 << 19) | (32'd1 << 16);
            21: m = (32'd1 << 20) | (32'd1 << 18);
            22: m = (32'd1 << 21) | (32'd1 << 20);
            23: m = (32'd1 << 22) | (32'd1 << 17);
            24: m = (32'd1 << 23) | (32'd1 << 22) | (32'd1 << 21) | (32'd1 << 16);
            25: m = (32'd1 << 24) | (32'd1 << 21);
            26: m = (32'd1 << 25) | (32'd1 << 5)  | (32'd1 << 1)  | (32'd1 << 0);
            27: m = (32'd1 << 26) | (32'd1 << 4)  | (32'd1 << 1)  | (32'd1 << 0);
            28: m = (32'd1 << 27) | (32'd1 << 24);
            29: m = (32'd1 << 28) | (32'd1 << 26);
            30: m = (32'd1 << 29) | (32'd1 << 5)  | (32'd1 << 3)  | (32'd1 << 0);
            31: m = (32'd1 << 30) | (32'd1 << 27);
            32: m = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1)  | (32'd1 << 0);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [31:0]      TAPS_ALL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V   = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONES     = '1;
    localparam int               CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_rand_multi: WIDTH=%0d outside 3..32", WIDTH);
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("lfsr_rand_multi: OUT_W=%0d outside 1..WIDTH", OUT_W);
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("lfsr_rand_multi: N_CH=%0d outside 1..16", N_CH);
    end
    if (SEED_V == ONES) begin : g_bad_seed
        $error("lfsr_rand_multi: SEED must not be all ones");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_HOLD
    } state_t;

    state_t                state_q;
    logic [WIDTH-1:0]      lfsr_q;
    logic [WIDTH-1:0]      lfsr_d;
    logic [CH_W-1:0]       ch_q;
    logic [N_CH*OUT_W-1:0] data_q;
    logic                  req_ready_q;
    logic                  rnd_valid_q;
    logic                  seed_err_q;
    logic                  fb;
    logic                  seed_in_ok;

    // With an even tap count the XNOR chain reduces to inverted parity; all ones would lock, so it reseeds.
    assign fb         = ~^(lfsr_q & TAPS);
    assign lfsr_d     = (lfsr_q == ONES) ? SEED_V : {lfsr_q[WIDTH-2:0], fb};
    assign seed_in_ok = (seed_in != ONES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_V;
            ch_q        <= '0;
            data_q      <= '0;
            req_ready_q <= 1'b1;
            rnd_valid_q <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            seed_err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (seed_load) begin
                        lfsr_q     <= seed_in_ok ? seed_in : SEED_V;
                        seed_err_q <= ~seed_in_ok;
                    end else begin
`ifdef LFSR_FREERUN_EN
                        lfsr_q <= lfsr_d;
`endif
                        if (req_valid) begin
                            state_q     <= S_GEN;
                            ch_q        <= '0;
                            req_ready_q <= 1'b0;
                        end
                    end
                end
                S_GEN: begin
                    lfsr_q                       <= lfsr_d;
                    data_q[ch_q*OUT_W +: OUT_W]  <= lfsr_d[OUT_W-1:0];
                    ch_q                         <= ch_q + 1'b1;
                    if (ch_q == CH_LAST) begin
                        state_q     <= S_HOLD;
                        rnd_valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
`ifdef LFSR_FREERUN_EN
                    lfsr_q <= lfsr_d;
`endif
                    if (rnd_ready) begin
                        state_q     <= S_IDLE;
                        rnd_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rnd_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = data_q;
    assign seed_err  = seed_err_q;

endmodule
